// File: rtl/scan_mult_bist_ctrl_if.sv
// Serial scan / auto-test signal bundle for scan_mult_bist_ctrl.
// The tester side drives the chain controls; the wrapper side returns status.
interface scan_mult_bist_ctrl_if;
    logic scan_in;
    logic scan_en;
    logic cap_en;
    logic start;
    logic exp_in;
    logic scan_out;
    logic busy;
    logic done;
    logic pass;

    modport master (
        output scan_in, scan_en, cap_en, start, exp_in,
        input  scan_out, busy, done, pass
    );

    modport slave (
        input  scan_in, scan_en, cap_en, start, exp_in,
        output scan_out, busy, done, pass
    );
endinterface

// File: rtl/scan_mult_bist_ctrl.sv
// Scan-chain test wrapper around a WxW unsigned multiplier.
// Supports manual shift/capture in IDLE and a self-sequencing load/capture/compare auto test.
module scan_mult_bist_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scan_mult_bist_ctrl_if.slave bus
);

    localparam int unsigned L  = 2 * W;
    localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [L-1:0]    chain_q, chain_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fail_q,  fail_d;
    logic            pass_q,  pass_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic [L-1:0]    prod_c;
    logic [L-1:0]    shift_c;
    logic            mismatch_c;
    logic            last_c;

    // Operands are the upper and lower halves of the chain; product is full width.
    assign prod_c     = L'(chain_q[L-1:W]) * L'(chain_q[W-1:0]);
    assign shift_c    = {bus.scan_in, chain_q[L-1:1]};
    assign mismatch_c = chain_q[0] ^ bus.exp_in;
    assign last_c     = (count_q == CW'(L - 1));

    // Next-state, chain and result logic.
    always_comb begin
        state_d = state_q;
        chain_d = chain_q;
        count_d = count_q;
        fail_d  = fail_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SHIFT_IN;
                    count_d = '0;
                    fail_d  = 1'b0;
                end else if (bus.scan_en) begin
                    chain_d = shift_c;
                end else if (bus.cap_en) begin
                    chain_d = prod_c;
                end
            end

            S_SHIFT_IN: begin
                chain_d = shift_c;
                if (last_c) begin
                    state_d = S_CAPTURE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            S_CAPTURE: begin
                chain_d = prod_c;
                state_d = S_SHIFT_OUT;
                count_d = '0;
            end

            S_SHIFT_OUT: begin
                chain_d = shift_c;
                fail_d  = fail_q | mismatch_c;
                if (last_c) begin
                    state_d = S_DONE;
                    count_d = '0;
                    pass_d  = ~(fail_q | mismatch_c);
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                count_d = '0;
            end

            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        busy_d = (state_d == S_SHIFT_IN) || (state_d == S_CAPTURE) ||
                 (state_d == S_SHIFT_OUT);
        done_d = (state_d == S_DONE);
    end

    // State register; synchronous active-low reset overrides any sequence in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            chain_q <= '0;
            count_q <= '0;
            fail_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            count_q <= count_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.scan_out = chain_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;

    // Status flags mirror the state register and are never set together.
    a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(busy_q && done_q));
    a_done_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        done_q |=> !done_q);

endmodule

// File: tb/tb_scan_mult_bist_ctrl.sv
// Directed bench for scan_mult_bist_ctrl: W=4 and W=8 instances on a shared clock/reset.
module tb_scan_mult_bist_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    scan_mult_bist_ctrl_if bus4();
    scan_mult_bist_ctrl_if bus8();

    scan_mult_bist_ctrl #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    scan_mult_bist_ctrl #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit use8, input logic si, input logic ei,
                         input logic se, input logic st, input logic ce);
        if (use8) begin
            bus8.scan_in = si; bus8.exp_in = ei; bus8.scan_en = se;
            bus8.start = st; bus8.cap_en = ce;
        end else begin
            bus4.scan_in = si; bus4.exp_in = ei; bus4.scan_en = se;
            bus4.start = st; bus4.cap_en = ce;
        end
    endtask

    task automatic observe(input bit use8, output logic so, output logic bsy,
                           output logic dn, output logic ps);
        if (use8) begin
            so = bus8.scan_out; bsy = bus8.busy; dn = bus8.done; ps = bus8.pass;
        end else begin
            so = bus4.scan_out; bsy = bus4.busy; dn = bus4.done; ps = bus4.pass;
        end
    endtask

    task automatic test_reset();
        logic so, bsy, dn, ps;
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        observe(1'b0, so, bsy, dn, ps);
        checks++;
        if ({so, bsy, dn, ps} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_w4: got so/busy/done/pass=%b required 0000", {so, bsy, dn, ps});
        end
        observe(1'b1, so, bsy, dn, ps);
        checks++;
        if ({so, bsy, dn, ps} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_w8: got so/busy/done/pass=%b required 0000", {so, bsy, dn, ps});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_manual();
        logic so, bsy, dn, ps;
        logic [7:0] vin;
        logic [7:0] vout;
        vin  = 8'h35;
        vout = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, vin[i], 1'b0, 1'b1, 1'b0, 1'b0);
            step();
        end
        observe(1'b0, so, bsy, dn, ps);
        checks++;
        if ({so, bsy, dn} !== 3'b100) begin
            failures++;
            $display("FAIL manual_load: got so/busy/done=%b required 100", {so, bsy, dn});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 8; i++) begin
            observe(1'b0, so, bsy, dn, ps);
            checks++;
            if (so !== vout[i]) begin
                failures++;
                $display("FAIL manual_out bit %0d: got %b required %b", i, so, vout[i]);
            end
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        observe(1'b0, so, bsy, dn, ps);
        checks++;
        if ({so, bsy, dn} !== 3'b000) begin
            failures++;
            $display("FAIL manual_drain: got so/busy/done=%b required 000", {so, bsy, dn});
        end
        step();
    endtask

    // Full auto sequence; prod is the true product, expv the stream fed on exp_in.
    task automatic auto_run(input string name, input bit use8, input int unsigned l,
                            input logic [15:0] vec, input logic [15:0] prod,
                            input logic [15:0] expv, input bit disturb,
                            input bit exp_pass);
        logic so, bsy, dn, ps;
        drive(use8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        observe(use8, so, bsy, dn, ps);
        checks++;
        if ({bsy, dn} !== 2'b10) begin
            failures++;
            $display("FAIL %s start: got busy/done=%b required 10", name, {bsy, dn});
        end
        for (int i = 0; i < int'(l); i++) begin
            drive(use8, vec[i], 1'b0, disturb && (i % 2 == 0), disturb && (i % 3 == 1),
                  disturb && (i == 4));
            step();
        end
        drive(use8, 1'b0, 1'b0, disturb, disturb, 1'b0);
        observe(use8, so, bsy, dn, ps);
        checks++;
        if ({bsy, dn} !== 2'b10) begin
            failures++;
            $display("FAIL %s shift_in: got busy/done=%b required 10", name, {bsy, dn});
        end
        step();
        for (int i = 0; i < int'(l); i++) begin
            observe(use8, so, bsy, dn, ps);
            checks++;
            if ({so, bsy, dn} !== {prod[i], 2'b10}) begin
                failures++;
                $display("FAIL %s out bit %0d: got so/busy/done=%b required %b",
                         name, i, {so, bsy, dn}, {prod[i], 2'b10});
            end
            drive(use8, 1'b0, expv[i], 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(use8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        observe(use8, so, bsy, dn, ps);
        checks++;
        if ({bsy, dn, ps} !== {2'b01, exp_pass}) begin
            failures++;
            $display("FAIL %s done: got busy/done/pass=%b required %b",
                     name, {bsy, dn, ps}, {2'b01, exp_pass});
        end
        step();
        observe(use8, so, bsy, dn, ps);
        checks++;
        if ({bsy, dn, ps} !== {2'b00, exp_pass}) begin
            failures++;
            $display("FAIL %s after_done: got busy/done/pass=%b required %b",
                     name, {bsy, dn, ps}, {2'b00, exp_pass});
        end
    endtask

    task automatic test_auto_pass();
        auto_run("auto_pass", 1'b0, 8, 16'h00FF, 16'h00E1, 16'h00E1, 1'b0, 1'b1);
    endtask

    task automatic test_auto_fail();
        logic so, bsy, dn, ps;
        auto_run("auto_fail", 1'b0, 8, 16'h00FF, 16'h00E1, 16'h00C1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        observe(1'b0, so, bsy, dn, ps);
        checks++;
        if ({ps, dn} !== 2'b00) begin
            failures++;
            $display("FAIL fail_hold: got pass/done=%b required 00", {ps, dn});
        end
    endtask

    task automatic test_robustness();
        auto_run("disturb", 1'b0, 8, 16'h0035, 16'h000F, 16'h000F, 1'b1, 1'b1);
        auto_run("zero_a", 1'b0, 8, 16'h000F, 16'h0000, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic so, bsy, dn, ps;
        logic [7:0] vec;
        vec = 8'hFF;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, vec[i], 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        observe(1'b0, so, bsy, dn, ps);
        checks++;
        if ({so, bsy, dn, ps} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid: got so/busy/done/pass=%b required 0000", {so, bsy, dn, ps});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            observe(1'b0, so, bsy, dn, ps);
            checks++;
            if ({so, bsy, dn} !== 3'b000) begin
                failures++;
                $display("FAIL reset_mid_idle cyc %0d: got so/busy/done=%b required 000",
                         i, {so, bsy, dn});
            end
        end
    endtask

    task automatic test_width8();
        auto_run("w8_200x100", 1'b1, 16, 16'hC864, 16'h4E20, 16'h4E20, 1'b0, 1'b1);
        auto_run("w8_max", 1'b1, 16, 16'hFFFF, 16'hFE01, 16'hFE01, 1'b0, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_manual();
        test_auto_pass();
        test_auto_fail();
        test_robustness();
        test_reset_mid();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
